// File: rtl/hsv_core_issue_multi.sv
// Issue stage: register file, per-register pending scoreboard and one output register feeding NUM_UNITS units.
// Optional HSV_ISSUE_BYPASS_EN forwards a same-cycle writeback into operands and the hazard check.
module hsv_core_issue_multi #(
  parameter int NUM_UNITS = 4,
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  localparam int RAW      = $clog2(NUM_REGS)
) (
  input  logic                 clk_core,
  input  logic                 rst_core,
  input  logic                 flush_req,
  output logic                 flush_ack,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_immediate,
  input  logic [RAW-1:0]       in_rs1_addr,
  input  logic [RAW-1:0]       in_rs2_addr,
  input  logic [RAW-1:0]       in_rd_addr,
  input  logic                 in_rd_write,
  input  logic [NUM_UNITS-1:0] in_unit_sel,
  output logic [XLEN-1:0]      out_pc,
  output logic [XLEN-1:0]      out_rs1,
  output logic [XLEN-1:0]      out_rs2,
  output logic [XLEN-1:0]      out_immediate,
  output logic [RAW-1:0]       out_rd_addr,
  output logic [NUM_UNITS-1:0] out_valid,
  input  logic [NUM_UNITS-1:0] out_ready,
  input  logic                 wr_en,
  input  logic [RAW-1:0]       wr_addr,
  input  logic [XLEN-1:0]      wr_data,
  output logic                 err_illegal_sel
);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rd;
  } disp_t;

  state_e                state_q, state_d;
  logic                  run, flush_go;
  logic [XLEN-1:0]       rf_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pend_q, pend_d, pend_eff;
  logic [NUM_UNITS-1:0]  ov_q, ov_d;
  disp_t                 disp_q, disp_d;
  logic                  err_q, err_d;
  logic [XLEN-1:0]       rs1_val, rs2_val;
  logic                  sel_onehot, hazard, drain, accept, issue_ok;

  // FSM: state register
  always_ff @(posedge clk_core) begin
    if (rst_core) state_q <= S_RUN;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush_req)  state_d = S_FLUSH;
      S_FLUSH: if (!flush_req) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run       = (state_q == S_RUN);
    flush_ack = (state_q == S_FLUSH);
  end

  assign flush_go   = run & flush_req;
  assign sel_onehot = (in_unit_sel != '0) &&
                      ((in_unit_sel & (in_unit_sel - NUM_UNITS'(1))) == '0);

  // Effective pending view; with bypass a same-cycle writeback already resolves its register.
  always_comb begin
    pend_eff = pend_q;
`ifdef HSV_ISSUE_BYPASS_EN
    if (wr_en) pend_eff[wr_addr] = 1'b0;
`endif
  end

  assign hazard = pend_eff[in_rs1_addr] | pend_eff[in_rs2_addr] |
                  (in_rd_write & pend_eff[in_rd_addr]);
  assign drain  = |(ov_q & out_ready);

  assign in_ready = ((ov_q == '0) | drain) & ~hazard & run & ~flush_req & ~rst_core;
  assign accept   = in_valid & in_ready;
  assign issue_ok = accept & sel_onehot;

  always_comb begin
    rs1_val = rf_q[in_rs1_addr];
    rs2_val = rf_q[in_rs2_addr];
`ifdef HSV_ISSUE_BYPASS_EN
    if (wr_en && wr_addr != '0 && wr_addr == in_rs1_addr) rs1_val = wr_data;
    if (wr_en && wr_addr != '0 && wr_addr == in_rs2_addr) rs2_val = wr_data;
`endif
  end

  always_comb begin
    ov_d   = ov_q;
    disp_d = disp_q;
    if (drain) ov_d = '0;
    if (issue_ok) begin
      ov_d       = in_unit_sel;
      disp_d.pc  = in_pc;
      disp_d.rs1 = rs1_val;
      disp_d.rs2 = rs2_val;
      disp_d.imm = in_immediate;
      disp_d.rd  = in_rd_addr;
    end
    if (flush_go) ov_d = '0;
  end

  // Set beats clear on the same register; flush wipes everything.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) pend_d[wr_addr] = 1'b0;
    if (issue_ok && in_rd_write && in_rd_addr != '0) pend_d[in_rd_addr] = 1'b1;
    if (flush_go) pend_d = '0;
    pend_d[0] = 1'b0;
  end

  assign err_d = accept & ~sel_onehot;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      ov_q   <= '0;
      disp_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else begin
      ov_q   <= ov_d;
      disp_q <= disp_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      if (wr_en && wr_addr != '0) rf_q[wr_addr] <= wr_data;
    end
  end

  assign out_valid       = ov_q;
  assign out_pc          = disp_q.pc;
  assign out_rs1         = disp_q.rs1;
  assign out_rs2         = disp_q.rs2;
  assign out_immediate   = disp_q.imm;
  assign out_rd_addr     = disp_q.rd;
  assign err_illegal_sel = err_q;

endmodule

// File: tb/tb_hsv_core_issue_multi.sv
// Directed self-checking bench for hsv_core_issue_multi (default 4 units, 32-bit, 32 regs).
module tb_hsv_core_issue_multi;
  localparam int NU = 4, XL = 32, NR = 32, RAW = 5;

  logic           clk_core = 0, rst_core = 1, flush_req = 0, flush_ack;
  logic           in_valid = 0, in_ready, in_rd_write = 0;
  logic [XL-1:0]  in_pc = 0, in_immediate = 0;
  logic [RAW-1:0] in_rs1_addr = 0, in_rs2_addr = 0, in_rd_addr = 0;
  logic [NU-1:0]  in_unit_sel = 0, out_valid, out_ready = '1;
  logic [XL-1:0]  out_pc, out_rs1, out_rs2, out_immediate;
  logic [RAW-1:0] out_rd_addr;
  logic           wr_en = 0, err_illegal_sel;
  logic [RAW-1:0] wr_addr = 0;
  logic [XL-1:0]  wr_data = 0;

  int checks = 0, errors = 0;

  hsv_core_issue_multi #(.NUM_UNITS(NU), .XLEN(XL), .NUM_REGS(NR)) dut (
    .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_immediate(in_immediate),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_rd_write(in_rd_write), .in_unit_sel(in_unit_sel),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_immediate(out_immediate),
    .out_rd_addr(out_rd_addr), .out_valid(out_valid), .out_ready(out_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err_illegal_sel(err_illegal_sel)
  );

  always #5 clk_core = ~clk_core;

  task automatic tick;
    @(posedge clk_core); #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [XL-1:0] pc, input logic [XL-1:0] imm,
                       input logic [RAW-1:0] rs1, input logic [RAW-1:0] rs2,
                       input logic [RAW-1:0] rd, input logic rdw, input logic [NU-1:0] sel);
    in_pc = pc; in_immediate = imm; in_rs1_addr = rs1; in_rs2_addr = rs2;
    in_rd_addr = rd; in_rd_write = rdw; in_unit_sel = sel; in_valid = 1;
  endtask

  task automatic wb(input logic [RAW-1:0] a, input logic [XL-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    // reset overrides in-flight traffic
    issue(32'h50, 0, 0, 0, 3, 1, 4'b0001);
    flush_req = 1; wb(2, 32'hFF);
    #1 check("rst_in_ready", in_ready, 0);
    tick; tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_flush_ack", flush_ack, 0);
    check("rst_err", err_illegal_sel, 0);
    check("rst_out_pc", out_pc, 0);
    rst_core = 0; flush_req = 0; wr_en = 0; in_valid = 0;

    // basic issue
    wb(1, 32'h12345678);
    tick; wr_en = 0;
    issue(32'h100, 4, 1, 0, 0, 0, 4'b0001);
    #1 check("basic_in_ready", in_ready, 1);
    tick; in_valid = 0;
    check("basic_out_valid", out_valid, 4'b0001);
    check("basic_rs1", out_rs1, 32'h12345678);
    check("basic_rs2", out_rs2, 0);
    check("basic_imm", out_immediate, 4);
    check("basic_pc", out_pc, 32'h100);

    // RAW hazard on x5
    issue(32'h104, 0, 0, 0, 5, 1, 4'b0010);
    tick;
    check("raw_rd_out", out_rd_addr, 5);
    issue(32'h108, 0, 5, 0, 0, 0, 4'b0001);
    #1 check("raw_stall0", in_ready, 0);
    tick;
    check("raw_stall1", in_ready, 0);
    wb(5, 32'hDEADBEEF);
    #1;
`ifdef HSV_ISSUE_BYPASS_EN
    check("raw_bypass_ready", in_ready, 1);
    tick; wr_en = 0; in_valid = 0;
`else
    check("raw_wb_cycle_stall", in_ready, 0);
    tick; wr_en = 0;
    #1 check("raw_ready_after_wb", in_ready, 1);
    tick; in_valid = 0;
`endif
    check("raw_out_valid", out_valid, 4'b0001);
    check("raw_out_pc", out_pc, 32'h108);
    check("raw_out_rs1", out_rs1, 32'hDEADBEEF);

    // x0 is hardwired and never pending; x2 write during reset was dropped
    wb(0, 32'h0BADF00D);
    tick; wr_en = 0;
    issue(32'h10C, 0, 0, 2, 0, 1, 4'b0100);
    #1 check("x0_ready", in_ready, 1);
    tick;
    check("x0_rs1", out_rs1, 0);
    check("x2_reset_rs2", out_rs2, 0);
    issue(32'h110, 0, 0, 0, 0, 0, 4'b1000);
    #1 check("x0_nostall", in_ready, 1);
    tick; in_valid = 0;
    check("x0_out_valid", out_valid, 4'b1000);
    tick;

    // back-pressure on unit 2; other units' ready is ignored
    out_ready = 4'b1011;
    issue(32'h200, 0, 1, 5, 0, 0, 4'b0100);
    tick;
    check("bp_out_valid", out_valid, 4'b0100);
    issue(32'h300, 0, 0, 0, 0, 0, 4'b0100);
    wb(1, 32'hAAAAAAAA);
    #1 check("bp_in_ready", in_ready, 0);
    tick; wr_en = 0;
    check("bp_pc_stable", out_pc, 32'h200);
    check("bp_rs1_captured", out_rs1, 32'h12345678);
    check("bp_rs2_captured", out_rs2, 32'hDEADBEEF);
    check("bp_valid_stable", out_valid, 4'b0100);
    out_ready = 4'b1111;
    #1 check("bp_drain_ready", in_ready, 1);
    tick; in_valid = 0;
    check("bp_next_pc", out_pc, 32'h300);
    check("bp_next_valid", out_valid, 4'b0100);
    tick;
    check("bp_drained", out_valid, 0);

    // flush with pending x7 and a full output stage; writeback during flush lands
    out_ready = 4'b0000;
    issue(32'h400, 0, 0, 0, 7, 1, 4'b0001);
    tick; in_valid = 0;
    check("fl_full", out_valid, 4'b0001);
    flush_req = 1;
    issue(32'h500, 0, 7, 3, 0, 0, 4'b0001);
    wb(3, 32'h33);
    #1 check("fl_in_ready", in_ready, 0);
    tick; wr_en = 0;
    check("fl_out_valid", out_valid, 0);
    check("fl_ack1", flush_ack, 1);
    tick;
    check("fl_ack2", flush_ack, 1);
    flush_req = 0; out_ready = 4'b1111;
    #1 check("fl_exit_ready", in_ready, 0);
    tick;
    check("fl_ack_done", flush_ack, 0);
    check("fl_rs1_7_ready", in_ready, 1);
    tick; in_valid = 0;
    check("fl_out_valid2", out_valid, 4'b0001);
    check("fl_out_pc", out_pc, 32'h500);
    check("fl_rs1", out_rs1, 0);
    check("fl_rs2_wb", out_rs2, 32'h33);

    // illegal unit select is dropped
    issue(32'h600, 0, 0, 0, 9, 1, 4'b0011);
    #1 check("ill_ready", in_ready, 1);
    tick; in_valid = 0;
    check("ill_no_valid", out_valid, 0);
    check("ill_err", err_illegal_sel, 1);
    tick;
    check("ill_err_pulse", err_illegal_sel, 0);
    issue(32'h604, 0, 9, 0, 0, 0, 4'b0001);
    #1 check("ill_sb_unchanged", in_ready, 1);
    tick; in_valid = 0;
    check("ill_follow_pc", out_pc, 32'h604);
    issue(32'h608, 0, 0, 0, 0, 0, 4'b0000);
    tick; in_valid = 0;
    check("zero_sel_err", err_illegal_sel, 1);
    check("zero_sel_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
